// File: rtl/decode_stage.sv
// Registered MIPS decode stage: valid/ready in and out, load-use and HI/LO interlocks, flush.
// Optional feature macro ILLEGAL_TRAP_EN adds an illegal bundle bit and a sticky trap output.
module decode_stage #(
    parameter int PC_W        = 32,
    parameter int MULT_CYCLES = 4,
    parameter int LINK_REG    = 31
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            regwrite,
    output logic            memtoreg,
    output logic            memwrite,
    output logic            alusrcbimm,
    output logic            orimm,
    output logic            lui,
    output logic            dojump,
    output logic            link,
    output logic            isbeq,
    output logic            isbltz,
    output logic [4:0]      destreg,
    output logic [2:0]      alucontrol
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic            illegal,
    output logic            trap
`endif
);
    typedef struct packed {
        logic       regwrite, memtoreg, memwrite, alusrcbimm, orimm;
        logic       lui, dojump, link, isbeq, isbltz;
        logic [4:0] destreg;
        logic [2:0] alucontrol;
    } ctrl_t;

    localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_AND  = 6'b100100,
                           F_OR   = 6'b100101, F_SLTU = 6'b101011, F_MULTU = 6'b011001,
                           F_MFHI = 6'b010000, F_MFLO = 6'b010010;
    localparam logic [2:0] ALU_MULTU = 3'b011;
    localparam logic [4:0] LINK      = 5'(LINK_REG);
    localparam logic [3:0] MCNT_LOAD = 4'(MULT_CYCLES);

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];

    ctrl_t dec;
    logic  uses_rs, uses_rt, is_hilo;

    // NOTE: every output gets a default first, so no path through the cases can infer a latch.
    always_comb begin
        dec     = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_hilo = 1'b0;
        case (opcode)
            6'b000000: begin
                uses_rs = (funct != F_MFHI) && (funct != F_MFLO);
                case (funct)
                    F_ADDU:  dec.alucontrol = 3'b010;
                    F_SUBU:  dec.alucontrol = 3'b110;
                    F_AND:   dec.alucontrol = 3'b000;
                    F_OR:    dec.alucontrol = 3'b001;
                    F_SLTU:  dec.alucontrol = 3'b111;
                    F_MULTU: dec.alucontrol = ALU_MULTU;
                    F_MFHI:  dec.alucontrol = 3'b100;
                    F_MFLO:  dec.alucontrol = 3'b101;
                    default: ;
                endcase
                case (funct)
                    F_ADDU, F_SUBU, F_AND, F_OR, F_SLTU: begin
                        dec.regwrite = 1'b1;
                        dec.destreg  = rd;
                        uses_rt      = 1'b1;
                    end
                    F_MULTU: begin
                        uses_rt = 1'b1;
                        is_hilo = 1'b1;
                    end
                    F_MFHI, F_MFLO: begin
                        dec.regwrite = 1'b1;
                        dec.destreg  = rd;
                        is_hilo      = 1'b1;
                    end
                    default: ;
                endcase
            end
            6'b100011: begin
                dec.alucontrol = 3'b010; dec.regwrite = 1'b1; dec.memtoreg = 1'b1;
                dec.alusrcbimm = 1'b1;   dec.destreg  = rt;   uses_rs      = 1'b1;
            end
            6'b101011: begin
                dec.alucontrol = 3'b010; dec.memwrite = 1'b1; dec.alusrcbimm = 1'b1;
                uses_rs = 1'b1;          uses_rt = 1'b1;
            end
            6'b000100: begin
                dec.alucontrol = 3'b110; dec.isbeq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
            end
            6'b000001: begin
                dec.alucontrol = 3'b111; dec.isbltz = 1'b1; uses_rs = 1'b1;
            end
            6'b001001: begin
                dec.alucontrol = 3'b010; dec.regwrite = 1'b1; dec.alusrcbimm = 1'b1;
                dec.destreg    = rt;     uses_rs      = 1'b1;
            end
            6'b001101: begin
                dec.alucontrol = 3'b001; dec.regwrite = 1'b1; dec.alusrcbimm = 1'b1;
                dec.orimm      = 1'b1;   dec.destreg  = rt;   uses_rs        = 1'b1;
            end
            6'b001111: begin
                dec.alucontrol = 3'b001; dec.regwrite = 1'b1; dec.alusrcbimm = 1'b1;
                dec.lui        = 1'b1;   dec.destreg  = rt;
            end
            6'b000010: dec.dojump = 1'b1;
            6'b000011: begin
                dec.dojump = 1'b1; dec.link = 1'b1; dec.regwrite = 1'b1; dec.destreg = LINK;
            end
            default: ;
        endcase
    end

    logic            valid_q, valid_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [3:0]      mcnt_q, mcnt_d;
    logic            blocked, load_use, mult_haz, hazard, accept, issue;

    // A held load only stalls consumers of its destination; $0 is never a real dependency.
    assign load_use = valid_q && ctrl_q.memtoreg && ctrl_q.regwrite && (ctrl_q.destreg != 5'd0) &&
                      ((uses_rs && rs == ctrl_q.destreg) || (uses_rt && rt == ctrl_q.destreg));
    assign mult_haz = is_hilo && ((mcnt_q != 4'd0) || (valid_q && ctrl_q.alucontrol == ALU_MULTU));
    assign hazard   = load_use || mult_haz;
    assign in_ready = !flush && !hazard && !blocked && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign issue    = valid_q && out_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        mcnt_d  = mcnt_q;
        if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
            pc_d    = in_pc;
            instr_d = instr;
        end else if (issue || flush) begin
            valid_d = 1'b0;
        end
        // Flush leaves the counter alone: a multu already in execute keeps occupying HI/LO.
        if (issue && ctrl_q.alucontrol == ALU_MULTU) begin
            mcnt_d = MCNT_LOAD;
        end else if (mcnt_q != 4'd0) begin
            mcnt_d = mcnt_q - 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            mcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            mcnt_q  <= mcnt_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d, trap_q, trap_d;

    // Every legal encoding sets at least one bundle field, so an all-zero decode is unknown.
    assign illegal_d = accept ? (dec == '0) : illegal_q;
    assign trap_d    = trap_q || (issue && illegal_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            trap_q    <= trap_d;
        end
    end

    assign illegal = illegal_q;
    assign trap    = trap_q;
    assign blocked = trap_q;
`else
    assign blocked = 1'b0;
`endif

    assign out_valid  = valid_q;
    assign out_pc     = pc_q;
    assign out_instr  = instr_q;
    assign regwrite   = ctrl_q.regwrite;
    assign memtoreg   = ctrl_q.memtoreg;
    assign memwrite   = ctrl_q.memwrite;
    assign alusrcbimm = ctrl_q.alusrcbimm;
    assign orimm      = ctrl_q.orimm;
    assign lui        = ctrl_q.lui;
    assign dojump     = ctrl_q.dojump;
    assign link       = ctrl_q.link;
    assign isbeq      = ctrl_q.isbeq;
    assign isbltz     = ctrl_q.isbltz;
    assign destreg    = ctrl_q.destreg;
    assign alucontrol = ctrl_q.alucontrol;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode table, directed interlock/flush/reset
// sequences and a randomized run against a mnemonic-level reference model.
module tb_decode_stage;
    localparam int PC_W = 32;
    localparam int MC   = 4;
    localparam int LINK = 31;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]     instr, out_instr;
    logic [PC_W-1:0] in_pc, out_pc;
    logic            regwrite, memtoreg, memwrite, alusrcbimm, orimm;
    logic            lui, dojump, link, isbeq, isbltz;
    logic [4:0]      destreg;
    logic [2:0]      alucontrol;
`ifdef ILLEGAL_TRAP_EN
    logic            illegal, trap;
`endif

    decode_stage #(.PC_W(PC_W), .MULT_CYCLES(MC), .LINK_REG(LINK)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .regwrite(regwrite), .memtoreg(memtoreg), .memwrite(memwrite),
        .alusrcbimm(alusrcbimm), .orimm(orimm), .lui(lui), .dojump(dojump),
        .link(link), .isbeq(isbeq), .isbltz(isbltz), .destreg(destreg),
        .alucontrol(alucontrol)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(illegal), .trap(trap)
`endif
    );

    always #5 clk = ~clk;

    // {regwrite,memtoreg,memwrite,alusrcbimm,orimm,lui,dojump,link,isbeq,isbltz,destreg,alucontrol}
    logic [17:0] bundle;
    assign bundle = {regwrite, memtoreg, memwrite, alusrcbimm, orimm, lui, dojump, link,
                     isbeq, isbltz, destreg, alucontrol};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        in_pc     = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef enum int {M_ADDU, M_SUBU, M_AND, M_OR, M_SLTU, M_MULTU, M_MFHI, M_MFLO, M_LW,
                      M_SW, M_BEQ, M_BLTZ, M_ADDIU, M_ORI, M_LUI, M_J, M_JAL, M_BAD} mn_t;

    typedef struct {
        mn_t         mn;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
    } op_t;

    function automatic op_t mk(input mn_t mn, input int rs, input int rt, input int rd);
        op_t o;
        o.mn  = mn;
        o.rs  = 5'(rs);
        o.rt  = 5'(rt);
        o.rd  = 5'(rd);
        o.imm = 16'h0007;
        o.tgt = 26'h0000040;
        return o;
    endfunction

    function automatic logic [31:0] enc(input op_t o);
        case (o.mn)
            M_ADDU:  return {6'd0, o.rs, o.rt, o.rd, 5'd0, 6'h21};
            M_SUBU:  return {6'd0, o.rs, o.rt, o.rd, 5'd0, 6'h23};
            M_AND:   return {6'd0, o.rs, o.rt, o.rd, 5'd0, 6'h24};
            M_OR:    return {6'd0, o.rs, o.rt, o.rd, 5'd0, 6'h25};
            M_SLTU:  return {6'd0, o.rs, o.rt, o.rd, 5'd0, 6'h2b};
            M_MULTU: return {6'd0, o.rs, o.rt, 10'd0, 6'h19};
            M_MFHI:  return {16'd0, o.rd, 5'd0, 6'h10};
            M_MFLO:  return {16'd0, o.rd, 5'd0, 6'h12};
            M_LW:    return {6'h23, o.rs, o.rt, o.imm};
            M_SW:    return {6'h2b, o.rs, o.rt, o.imm};
            M_BEQ:   return {6'h04, o.rs, o.rt, o.imm};
            M_BLTZ:  return {6'h01, o.rs, 5'd0, o.imm};
            M_ADDIU: return {6'h09, o.rs, o.rt, o.imm};
            M_ORI:   return {6'h0d, o.rs, o.rt, o.imm};
            M_LUI:   return {6'h0f, 5'd0, o.rt, o.imm};
            M_J:     return {6'h02, o.tgt};
            M_JAL:   return {6'h03, o.tgt};
            default: return {6'h3f, o.rs, o.rt, o.imm};
        endcase
    endfunction

    // Expected control bundle straight from the instruction's meaning.
    function automatic logic [17:0] exp_of(input op_t o);
        logic       rw, mtr, mw, bimm, orf, luf, dj, lk, bq, bz;
        logic [4:0] d;
        logic [2:0] a;
        {rw, mtr, mw, bimm, orf, luf, dj, lk, bq, bz} = '0;
        d = '0;
        a = '0;
        case (o.mn)
            M_ADDU:  begin rw = 1; d = o.rd; a = 3'b010; end
            M_SUBU:  begin rw = 1; d = o.rd; a = 3'b110; end
            M_AND:   begin rw = 1; d = o.rd; a = 3'b000; end
            M_OR:    begin rw = 1; d = o.rd; a = 3'b001; end
            M_SLTU:  begin rw = 1; d = o.rd; a = 3'b111; end
            M_MULTU: a = 3'b011;
            M_MFHI:  begin rw = 1; d = o.rd; a = 3'b100; end
            M_MFLO:  begin rw = 1; d = o.rd; a = 3'b101; end
            M_LW:    begin rw = 1; mtr = 1; bimm = 1; d = o.rt; a = 3'b010; end
            M_SW:    begin mw = 1; bimm = 1; a = 3'b010; end
            M_BEQ:   begin bq = 1; a = 3'b110; end
            M_BLTZ:  begin bz = 1; a = 3'b111; end
            M_ADDIU: begin rw = 1; bimm = 1; d = o.rt; a = 3'b010; end
            M_ORI:   begin rw = 1; bimm = 1; orf = 1; d = o.rt; a = 3'b001; end
            M_LUI:   begin rw = 1; bimm = 1; luf = 1; d = o.rt; a = 3'b001; end
            M_J:     dj = 1;
            M_JAL:   begin rw = 1; dj = 1; lk = 1; d = 5'(LINK); end
            default: ;
        endcase
        return {rw, mtr, mw, bimm, orf, luf, dj, lk, bq, bz, d, a};
    endfunction

    function automatic bit reads_rs(input mn_t m);
        return m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_SLTU, M_MULTU, M_LW, M_SW,
                         M_BEQ, M_BLTZ, M_ADDIU, M_ORI};
    endfunction

    function automatic bit reads_rt(input mn_t m);
        return m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_SLTU, M_MULTU, M_SW, M_BEQ};
    endfunction

    // Reference model: one held slot plus the edge number at which HI/LO becomes free.
    task automatic random_run(input int cycles);
        bit          m_valid = 0;
        op_t         m_op, o;
        logic [31:0] m_pc = '0, m_instr = '0;
        int          n = 0, busy_until = 0;
        bit          lu, mh, exp_ready, acc, iss;
        int          max_mn;
`ifdef ILLEGAL_TRAP_EN
        max_mn = M_JAL;
`else
        max_mn = M_BAD;
`endif
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            o     = mk(mn_t'($urandom_range(max_mn)), $urandom_range(3), $urandom_range(3),
                       $urandom_range(3));
            o.imm = 16'($urandom());
            o.tgt = 26'($urandom());
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(9) < 7);
            flush     = ($urandom_range(19) == 0);
            instr     = enc(o);
            in_pc     = $urandom();
            #1;
            lu = m_valid && m_op.mn == M_LW && m_op.rt != 0 &&
                 ((reads_rs(o.mn) && o.rs == m_op.rt) || (reads_rt(o.mn) && o.rt == m_op.rt));
            mh = (o.mn inside {M_MULTU, M_MFHI, M_MFLO}) &&
                 (n < busy_until || (m_valid && m_op.mn == M_MULTU));
            exp_ready = !flush && !lu && !mh && (!m_valid || out_ready);
            check("rand in_ready", in_ready, exp_ready);
            acc = in_valid && exp_ready;
            iss = m_valid && out_ready && !flush;
            if (iss && m_op.mn == M_MULTU) busy_until = n + 1 + MC;
            if (acc) begin
                m_valid = 1; m_op = o; m_pc = in_pc; m_instr = instr;
            end else if (iss || flush) begin
                m_valid = 0;
            end
            tick();
            n++;
            check("rand out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("rand bundle", bundle, exp_of(m_op));
                check("rand out_pc", out_pc, m_pc);
                check("rand out_instr", out_instr, m_instr);
            end
        end
        idle();
    endtask

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [17:0] exp;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        int   k;

        tbl.push_back('{"addu",  {6'd0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h21}, {10'b1000000000, 5'd9, 3'b010}});
        tbl.push_back('{"subu",  {6'd0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h23}, {10'b1000000000, 5'd9, 3'b110}});
        tbl.push_back('{"and",   {6'd0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h24}, {10'b1000000000, 5'd9, 3'b000}});
        tbl.push_back('{"or",    {6'd0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h25}, {10'b1000000000, 5'd9, 3'b001}});
        tbl.push_back('{"sltu",  {6'd0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h2b}, {10'b1000000000, 5'd9, 3'b111}});
        tbl.push_back('{"multu", {6'd0, 5'd1, 5'd2, 10'd0, 6'h19},       {10'b0000000000, 5'd0, 3'b011}});
        tbl.push_back('{"mfhi",  {16'd0, 5'd5, 5'd0, 6'h10},             {10'b1000000000, 5'd5, 3'b100}});
        tbl.push_back('{"mflo",  {16'd0, 5'd3, 5'd0, 6'h12},             {10'b1000000000, 5'd3, 3'b101}});
        tbl.push_back('{"lw",    {6'h23, 5'd1, 5'd8, 16'h0010},          {10'b1101000000, 5'd8, 3'b010}});
        tbl.push_back('{"sw",    {6'h2b, 5'd1, 5'd8, 16'h0010},          {10'b0011000000, 5'd0, 3'b010}});
        tbl.push_back('{"beq",   {6'h04, 5'd1, 5'd2, 16'hfffe},          {10'b0000000010, 5'd0, 3'b110}});
        tbl.push_back('{"bltz",  {6'h01, 5'd1, 5'd0, 16'h0004},          {10'b0000000001, 5'd0, 3'b111}});
        tbl.push_back('{"addiu", {6'h09, 5'd4, 5'd4, 16'h0007},          {10'b1001000000, 5'd4, 3'b010}});
        tbl.push_back('{"ori",   {6'h0d, 5'd1, 5'd2, 16'h00ff},          {10'b1001100000, 5'd2, 3'b001}});
        tbl.push_back('{"lui",   {6'h0f, 5'd0, 5'd6, 16'h1234},          {10'b1001010000, 5'd6, 3'b001}});
        tbl.push_back('{"j",     {6'h02, 26'h0000100},                   {10'b0000001000, 5'd0, 3'b000}});
        tbl.push_back('{"jal",   {6'h03, 26'h0000100},                   {10'b1000001100, 5'd31, 3'b000}});
`ifndef ILLEGAL_TRAP_EN
        tbl.push_back('{"op3f",  {6'h3f, 5'd1, 5'd2, 16'h0000},          {10'b0000000000, 5'd0, 3'b000}});
        tbl.push_back('{"sll",   {6'd0, 5'd0, 5'd2, 5'd3, 5'd4, 6'h00},  {10'b0000000000, 5'd0, 3'b000}});
`endif

        reset = 1'b1;
        idle();

        // Decode sweep.
        foreach (tbl[i]) begin
            do_reset();
            in_valid = 1'b1;
            instr    = tbl[i].ins;
            #1;
            check({"sweep in_ready ", tbl[i].name}, in_ready, 1'b1);
            tick();
            in_valid = 1'b0;
            check({"sweep out_valid ", tbl[i].name}, out_valid, 1'b1);
            check({"sweep bundle ", tbl[i].name}, bundle, tbl[i].exp);
            check({"sweep out_instr ", tbl[i].name}, out_instr, tbl[i].ins);
`ifdef ILLEGAL_TRAP_EN
            check({"sweep illegal ", tbl[i].name}, illegal, 1'b0);
`endif
        end

        // Reset mid-stream: async clear, then first accept visible one edge after release.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        instr     = enc(mk(M_ADDIU, 4, 4, 0));
        in_pc     = 32'h100;
        tick();
        check("pre-reset out_valid", out_valid, 1'b1);
        #3 reset = 1'b1;
        #2;
        check("async reset out_valid", out_valid, 1'b0);
        check("async reset bundle", bundle, 18'd0);
        check("async reset out_pc", out_pc, 32'd0);
        check("async reset out_instr", out_instr, 32'd0);
        tick();
        check("reset held out_valid", out_valid, 1'b0);
        reset = 1'b0;
        #1;
        check("post-reset in_ready", in_ready, 1'b1);
        tick();
        check("post-reset out_valid", out_valid, 1'b1);
        check("post-reset out_pc", out_pc, 32'h100);

        // Load-use: lw $8 then addu $9,$8,$10 -> one bubble.
        do_reset();
        in_valid = 1'b1;
        instr    = enc(mk(M_LW, 1, 8, 0));
        tick();
        instr = enc(mk(M_ADDU, 8, 10, 9));
        #1;
        check("load-use stall in_ready", in_ready, 1'b0);
        tick();
        check("load-use bubble out_valid", out_valid, 1'b0);
        check("load-use resume in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("load-use addu out_valid", out_valid, 1'b1);
        check("load-use addu bundle", bundle, {10'b1000000000, 5'd9, 3'b010});
        tick();
        check("load-use addu issued", out_valid, 1'b0);

        // lw $0 never interlocks.
        do_reset();
        in_valid = 1'b1;
        instr    = enc(mk(M_LW, 1, 0, 0));
        tick();
        instr = enc(mk(M_ADDU, 0, 10, 9));
        #1;
        check("lw0 in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("lw0 no bubble destreg", destreg, 5'd9);

        // multu then mflo: mflo accepted MULT_CYCLES+1 edges after multu issues.
        do_reset();
        in_valid = 1'b1;
        instr    = enc(mk(M_MULTU, 1, 2, 0));
        tick();
        check("multu alucontrol", alucontrol, 3'b011);
        instr = enc(mk(M_MFLO, 0, 0, 3));
        k = 0;
        while (!(out_valid && alucontrol == 3'b101) && k < 20) begin
            tick();
            k++;
        end
        check("mflo latency edges", k, MC + 2);
        check("mflo bundle", bundle, {10'b1000000000, 5'd3, 3'b101});
        instr = enc(mk(M_MFHI, 0, 0, 5));
        tick();
        in_valid = 1'b0;
        check("mfhi alucontrol", alucontrol, 3'b100);
        check("mfhi destreg", destreg, 5'd5);

        // Backpressure: held addiu stays stable for three stalled cycles.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        instr     = enc(mk(M_ADDIU, 4, 4, 0));
        in_pc     = 32'h200;
        tick();
        instr = enc(mk(M_ORI, 1, 2, 0));
        in_pc = 32'h204;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp in_ready", in_ready, 1'b0);
            check("bp bundle", bundle, {10'b1001000000, 5'd4, 3'b010});
            check("bp out_pc", out_pc, 32'h200);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("bp next out_valid", out_valid, 1'b1);
        check("bp next out_pc", out_pc, 32'h204);
        tick();
        check("bp next issued", out_valid, 1'b0);

        // Flush with out_ready while beq is held and j is waiting.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        instr     = enc(mk(M_BEQ, 1, 2, 0));
        tick();
        instr     = enc(mk(M_J, 0, 0, 0));
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        check("flush in_ready", in_ready, 1'b0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", out_valid, 1'b0);
        tick();
        check("flush nothing accepted", out_valid, 1'b0);

        // A flushed multu never issued, so mflo may follow at once.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        instr     = enc(mk(M_MULTU, 1, 2, 0));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b1;
        instr    = enc(mk(M_MFLO, 0, 0, 3));
        #1;
        check("flushed multu no hilo stall", in_ready, 1'b1);

        // Flush after multu issued keeps the HI/LO counter running.
        do_reset();
        in_valid = 1'b1;
        instr    = enc(mk(M_MULTU, 1, 2, 0));
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b1;
        instr    = enc(mk(M_MFHI, 0, 0, 5));
        #1;
        check("counter survives flush", in_ready, 1'b0);
        in_valid = 1'b0;

        random_run(3000);

`ifdef ILLEGAL_TRAP_EN
        // Unknown opcode: NOP with illegal, sticky trap after issue, intake locked.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        instr     = {6'h3f, 26'd0};
        tick();
        check("illegal bundle", bundle, 18'd0);
        check("illegal bit", illegal, 1'b1);
        check("trap before issue", trap, 1'b0);
        out_ready = 1'b1;
        instr     = enc(mk(M_ADDIU, 4, 4, 0));
        tick();
        check("trap after issue", trap, 1'b1);
        check("trap in_ready", in_ready, 1'b0);
        tick();
        check("trap no accept", out_valid, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("trap survives flush", trap, 1'b1);
        check("trap in_ready stuck", in_ready, 1'b0);
        do_reset();
        check("trap cleared by reset", trap, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
